mux8_arbiter: RTL and testbench
===============================

# mux8_arbiter

Round-robin arbiter that shares one 8-input resource among eight requesters in the 16-bit MIPS datapath. It produces the 3-bit select for an 8-to-1 multiplexer bank (one `mux8to1` per data bit) plus a one-hot grant. Each owner holds the grant until it signals `done` or drops its request. An optional hold limit forces the owner off the resource when other requesters are waiting.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while others wait; range 1..255; 0 disables preemption.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  8  request per requester; bit i = requester i.
- `done`  input  1  current owner finished; sampled only while `busy`=1.
- `gnt`  output  8  one-hot grant, or all zero when idle; registered.
- `sel`  output  3  index of the granted requester; drives the mux select lines; registered.
- `busy`  output  1  1 while a grant is active (`gnt` != 0).
- `preempt`  output  1  one-cycle pulse: the previous owner was forced off by the hold limit.

## Operation
- State: IDLE / GRANT, plus a 3-bit priority pointer `ptr` and an 8-bit hold counter `hcnt`.
- Winner search: the first set bit of the candidate vector, scanning `ptr`, `ptr+1`, … `ptr+7` (mod 8, wrap 7→0).
- IDLE, with `req`!=0: move to GRANT.
  - `gnt` = one-hot(winner), `sel` = winner, `ptr` = winner+1 mod 8, `hcnt` = 0.
- IDLE, with `req`=0: stay in IDLE; `gnt`=0; `sel` holds its last value.
- GRANT, release condition, evaluated each cycle; any one of these triggers release:
  - (a) `done`=1;
  - (b) `req[sel]`=0;
  - (c) `MAX_HOLD`!=0, `hcnt`=`MAX_HOLD`-1, and (`req` with bit `sel` masked) != 0.
- GRANT, no release: `hcnt` increments, saturating at 255; `gnt` and `sel` are unchanged.
- GRANT, release: arbitrate over `req` with the current owner's bit masked.
  - If a winner exists: hand over directly with no idle cycle. Update `gnt`, `sel`, `ptr` and `hcnt`=0 as above; stay in GRANT.
  - If no winner: go to IDLE, `gnt`=0. An owner that still holds `req` is re-granted on the next cycle.
- Priority between conditions: (a) and (b) take precedence over (c). `preempt` is set only when (c) alone causes the release.
- `preempt` is registered and asserted for exactly the one cycle in which the new owner's `gnt` first appears.
- The single-owner invariant holds on every cycle: `popcount(gnt)` ≤ 1, and `gnt`=1<<`sel` whenever `busy`=1.

## Timing
- Reset (`rst_n`=0 at a rising edge): `gnt`=0, `sel`=0, `busy`=0, `preempt`=0, `ptr`=0, `hcnt`=0, state IDLE. This applies mid-grant too: the grant drops on that edge with no `preempt`.
- Request-to-grant latency is 1 cycle: `req` sampled at edge N gives `gnt` valid after edge N.
- Handover latency is 1 cycle: a release seen at edge N puts the new `gnt` after edge N, so the bus is never idle between owners.
- The owner sees the resource for `MAX_HOLD` cycles before forced release.
- `done` and `req` changes in the same cycle as the grant are ignored until the grant is visible; the first evaluation happens on the edge after the grant.
- Outputs have no combinational path from inputs.

## Test plan
- **Reset / idle.** Hold `rst_n`=0 for 2 cycles, then `req`=0 for 5 cycles → `gnt`=0, `sel`=0, `busy`=0, `preempt`=0 throughout.
- **Round-robin order.** `req`=8'hFF held, `done` pulsed 1 cycle after each grant → grant order 0,1,2,…,7,0; `sel` wraps 7→0; no idle cycle between grants.
- **Back-to-back / idle gap.** Only `req[3]`=1 with `done` pulsed → `gnt`=8'h08, then one IDLE cycle with `gnt`=0, then `gnt`=8'h08 again.
- **Preemption.** `MAX_HOLD`=4, `req`=8'h05, no `done` → `gnt`=8'h01 for exactly 4 cycles, then `gnt`=8'h04 with `preempt`=1 for one cycle. With `req[2]` still 1, after a further 4 cycles `gnt`=8'h01 with `preempt`=1.
- **Preemption off and drop.** `MAX_HOLD`=0, `req`=8'h81 for 300 cycles → `gnt`=8'h01 is held all 300 cycles (counter saturates, no preempt). Then drop `req[0]` → next edge `gnt`=8'h80.
- **Reset mid-grant.** Pulse `rst_n`=0 while `gnt`=8'h20 → next edge `gnt`=0. After release with `req`=8'h21, `gnt`=8'h01, because `ptr` has been reset to 0.

Source files
------------

// File: rtl/mux8_arbiter_if.sv
// mux8_arbiter_if: requester/grant bundle between the eight requesters and the
// round-robin arbiter.
//   req     : request per requester (bit i = requester i)
//   done    : current owner finished (only looked at while busy)
//   gnt     : one-hot grant, zero when idle
//   sel     : index of the granted requester (mux select)
//   busy    : a grant is active
//   preempt : one-cycle pulse, previous owner forced off by the hold limit
interface mux8_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       preempt;

  modport master (output req, done, input gnt, sel, busy, preempt);
  modport slave  (input req, done, output gnt, sel, busy, preempt);
endinterface

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin arbiter for one shared 8-input resource. Produces a
// registered one-hot grant and the matching 3-bit mux select. The owner keeps
// the grant until done, until it drops its request, or (MAX_HOLD != 0) until
// it has held the resource MAX_HOLD cycles while someone else is waiting.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of mux8_arbiter_if (req/done in; gnt/sel/busy/preempt out)
module mux8_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  mux8_arbiter_if.slave  bus
);

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_gnt,   w_gnt_nxt;
  logic [2:0] r_sel,   w_sel_nxt;
  logic [2:0] r_ptr,   w_ptr_nxt;
  logic [7:0] r_hcnt,  w_hcnt_nxt;
  logic       r_pre,   w_pre_nxt;

  logic [7:0] w_cand;
  logic       w_found;
  logic [2:0] w_win;
  logic       w_rel_a, w_rel_b, w_rel_c;

  // While granted, the owner is masked out so a release hands over to someone
  // else; in idle every requester competes.
  assign w_cand = (r_state == S_GRANT) ? (bus.req & ~(8'd1 << r_sel)) : bus.req;

  // First set bit scanning ptr, ptr+1, ... (mod 8). Iterating k downwards lets
  // the lowest offset overwrite later, so it wins.
  always_comb begin
    logic [2:0] idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      idx = r_ptr + 3'(k);
      if (w_cand[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_rel_a = bus.done;
  assign w_rel_b = ~bus.req[r_sel];
  assign w_rel_c = HOLD_EN && (r_hcnt == HOLD_LAST) && (w_cand != 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    w_pre_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = 8'd0;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = 8'd1 << w_win;
          w_sel_nxt   = w_win;
          w_ptr_nxt   = w_win + 3'd1;
          w_hcnt_nxt  = 8'd0;
        end
      end
      S_GRANT: begin
        if (w_rel_a || w_rel_b || w_rel_c) begin
          if (w_found) begin
            w_gnt_nxt  = 8'd1 << w_win;
            w_sel_nxt  = w_win;
            w_ptr_nxt  = w_win + 3'd1;
            w_hcnt_nxt = 8'd0;
            // Only a pure hold-limit release counts as a preemption.
            w_pre_nxt  = w_rel_c && !w_rel_a && !w_rel_b;
          end else begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 8'd0;
          end
        end else if (r_hcnt != 8'hFF) begin
          w_hcnt_nxt = r_hcnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_hcnt  <= 8'd0;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_pre   <= w_pre_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.sel     = r_sel;
  assign bus.busy    = (r_state == S_GRANT);
  assign bus.preempt = r_pre;

endmodule

// File: tb/tb_mux8_arbiter.sv
// tb_mux8_arbiter: three arbiters (MAX_HOLD = 16, 4, 0) on one clock, each
// with its own interface. A reference model tracks owner / pointer / cycles
// held per instance from the arbitration rules and is advanced on every edge.
module tb_mux8_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] t_req  [3];
  logic       t_done [3];
  logic [7:0] o_gnt  [3];
  logic [2:0] o_sel  [3];
  logic       o_busy [3];
  logic       o_pre  [3];

  int n_run  = 0;
  int n_fail = 0;

  function automatic int hold_of(int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 0;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux8_arbiter_if bus ();
    assign bus.req  = t_req[g];
    assign bus.done = t_done[g];
    assign o_gnt[g]  = bus.gnt;
    assign o_sel[g]  = bus.sel;
    assign o_busy[g] = bus.busy;
    assign o_pre[g]  = bus.preempt;
    mux8_arbiter #(.MAX_HOLD((g == 0) ? 16 : (g == 1) ? 4 : 0)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner [3];   // -1 when idle
  int m_ptr   [3];
  int m_held  [3];   // cycles the current owner has had the grant visible
  int m_sel   [3];
  bit m_pre   [3];

  function automatic int find_first(logic [7:0] v, int p);
    for (int k = 0; k < 8; k++)
      if (v[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_step(int d);
    logic [7:0] others;
    bit ra, rb, rc;
    int w;
    if (!rst_n) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_held[d] = 0; m_sel[d] = 0; m_pre[d] = 0;
    end else if (m_owner[d] < 0) begin
      m_pre[d] = 0;
      w = find_first(t_req[d], m_ptr[d]);
      if (w >= 0) begin
        m_owner[d] = w; m_sel[d] = w; m_ptr[d] = (w + 1) % 8; m_held[d] = 1;
      end
    end else begin
      others = t_req[d];
      others[m_owner[d]] = 1'b0;
      ra = t_done[d];
      rb = !t_req[d][m_owner[d]];
      rc = (hold_of(d) != 0) && (m_held[d] == hold_of(d)) && (others != 0);
      m_pre[d] = 0;
      if (ra || rb || rc) begin
        w = find_first(others, m_ptr[d]);
        if (w >= 0) begin
          m_pre[d]   = rc && !ra && !rb;
          m_owner[d] = w; m_sel[d] = w; m_ptr[d] = (w + 1) % 8; m_held[d] = 1;
        end else begin
          m_owner[d] = -1;
        end
      end else begin
        m_held[d]++;
      end
    end
  endtask

  function automatic logic [13:0] exp_vec(int d);
    logic [7:0] g;
    g = (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
    return {g, 3'(m_sel[d]), (m_owner[d] >= 0), m_pre[d]};
  endfunction

  // Advance one clock: the model sees the same inputs the DUT sampled.
  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin t_req[d] = 8'h00; t_done[d] = 1'b0; end
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin t_req[d] = 8'h00; t_done[d] = 1'b0; end
    for (int c = 0; c < 7; c++) begin
      if (c == 2) rst_n = 1'b1;
      cyc();
      for (int d = 0; d < 3; d++) begin
        n_run++;
        if ({o_gnt[d], o_sel[d], o_busy[d], o_pre[d]} !== 14'd0) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cyc%0d: gnt=%h sel=%0d busy=%b pre=%b, want all 0",
                   d, c, o_gnt[d], o_sel[d], o_busy[d], o_pre[d]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    t_req[0] = 8'hFF;
    cyc();
    for (int k = 0; k < 9; k++) begin
      n_run++;
      if (o_gnt[0] !== (8'd1 << (k % 8)) || o_sel[0] !== 3'(k % 8) || o_pre[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL round_robin step%0d: gnt=%h sel=%0d pre=%b, want gnt=%h sel=%0d pre=0",
                 k, o_gnt[0], o_sel[0], o_pre[0], 8'd1 << (k % 8), k % 8);
      end
      cyc();
      t_done[0] = 1'b1;
      cyc();
      t_done[0] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want[0] = 8'h08; want[1] = 8'h00; want[2] = 8'h08;
    do_reset();
    t_req[0] = 8'h08;
    for (int k = 0; k < 3; k++) begin
      cyc();
      t_done[0] = (k == 0);
      n_run++;
      if (o_gnt[0] !== want[k] || o_busy[0] !== (want[k] != 0)) begin
        n_fail++;
        $display("FAIL back_to_back step%0d: gnt=%h busy=%b, want gnt=%h", k, o_gnt[0], o_busy[0], want[k]);
      end
    end
    t_done[0] = 1'b0;
  endtask

  task automatic test_preempt();
    logic [7:0] eg;
    bit ep;
    do_reset();
    t_req[1] = 8'h05;
    for (int c = 0; c < 9; c++) begin
      cyc();
      eg = (c < 4 || c == 8) ? 8'h01 : 8'h04;
      ep = (c == 4 || c == 8);
      n_run++;
      if (o_gnt[1] !== eg || o_pre[1] !== ep) begin
        n_fail++;
        $display("FAIL preempt cyc%0d: gnt=%h pre=%b, want gnt=%h pre=%b", c, o_gnt[1], o_pre[1], eg, ep);
      end
    end
  endtask

  task automatic test_no_preempt_drop();
    int bad = 0;
    do_reset();
    t_req[2] = 8'h81;
    for (int c = 0; c < 300; c++) begin
      cyc();
      if (o_gnt[2] !== 8'h01 || o_pre[2] !== 1'b0) bad++;
    end
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_off_300: %0d cycles deviated, want gnt=01 pre=0 on all 300", bad);
    end
    t_req[2] = 8'h80;
    cyc();
    n_run++;
    if (o_gnt[2] !== 8'h80 || o_sel[2] !== 3'd7 || o_pre[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_handover: gnt=%h sel=%0d pre=%b, want gnt=80 sel=7 pre=0", o_gnt[2], o_sel[2], o_pre[2]);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    t_req[0] = 8'h20;
    cyc();
    n_run++;
    if (o_gnt[0] !== 8'h20) begin
      n_fail++;
      $display("FAIL mid_reset_setup: gnt=%h, want 20", o_gnt[0]);
    end
    t_req[0] = 8'h21;
    rst_n = 1'b0;
    cyc();
    n_run++;
    if (o_gnt[0] !== 8'h00 || o_sel[0] !== 3'd0 || o_busy[0] !== 1'b0 || o_pre[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: gnt=%h sel=%0d busy=%b pre=%b, want 0", o_gnt[0], o_sel[0], o_busy[0], o_pre[0]);
    end
    rst_n = 1'b1;
    cyc();
    n_run++;
    if (o_gnt[0] !== 8'h01 || o_sel[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_reset_ptr: gnt=%h sel=%0d, want gnt=01 sel=0", o_gnt[0], o_sel[0]);
    end
  endtask

  task automatic test_random();
    logic [13:0] e;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 3) == 0) t_req[d] = 8'($urandom) & 8'($urandom);
        t_done[d] = ($urandom_range(0, 5) == 0);
      end
      cyc();
      for (int d = 0; d < 3; d++) begin
        e = exp_vec(d);
        n_run++;
        if ({o_gnt[d], o_sel[d], o_busy[d], o_pre[d]} !== e) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: gnt=%h sel=%0d busy=%b pre=%b, want gnt=%h sel=%0d busy=%b pre=%b",
                   d, c, o_gnt[d], o_sel[d], o_busy[d], o_pre[d], e[13:6], e[5:3], e[1], e[0]);
        end
        n_run++;
        if ((o_gnt[d] & (o_gnt[d] - 8'd1)) != 0 || (o_busy[d] && o_gnt[d] !== (8'd1 << o_sel[d]))) begin
          n_fail++;
          $display("FAIL one_owner dut%0d cyc%0d: gnt=%h sel=%0d busy=%b, want one-hot gnt matching sel",
                   d, c, o_gnt[d], o_sel[d], o_busy[d]);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_preempt();
    test_no_preempt_drop();
    test_reset_mid_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
